// File: rtl/xor_sched_pkg.sv
// Shared definitions for the XOR parity scheduler: FSM encoding, defaults, width helper.
`default_nettype none

package xor_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int DEF_N_REQ = 4;
   localparam int DEF_WIDTH = 8;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/xor_gate.sv
// Single 2-input XOR cell: the shared 1-bit datapath that the scheduler time-multiplexes.
`default_nettype none

module xor_gate (
   input  logic i_a,
   input  logic i_b,
   output logic o_y
);

   assign o_y = i_a ^ i_b;

endmodule

`default_nettype wire

// File: rtl/xor_parity_arbiter.sv
// +--------------------------------------------------------------------------+
// | xor_parity_arbiter: round-robin scheduler folding one requester word     |
// | per job through a shared serial XOR cell.                    Rev 1.0     |
// +--------------------------------------------------------------------------+
`default_nettype none

module xor_parity_arbiter
   import xor_sched_pkg::*;
#(
   parameter  int N_REQ = DEF_N_REQ,
   parameter  int WIDTH = DEF_WIDTH,
   localparam int ID_W  = clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   res_valid,
   output logic                   res_parity,
   output logic [ID_W-1:0]        res_id,
   input  logic                   res_ready
);

   localparam int              CNT_W    = clog2(WIDTH);
   localparam logic [CNT_W-1:0] c_last  = CNT_W'(WIDTH - 1);
   localparam logic [ID_W-1:0]  c_id_max = ID_W'(N_REQ - 1);
   localparam logic [ID_W:0]    c_n      = (ID_W + 1)'(N_REQ);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WIDTH-1:0]  r_sh;
   logic              r_acc;
   logic [CNT_W-1:0]  r_cnt;
   logic [ID_W-1:0]   r_id;
   logic [ID_W-1:0]   r_ptr;

   logic [N_REQ-1:0]  w_rot;
   logic              w_found;
   logic [ID_W-1:0]   w_off;
   logic [ID_W:0]     w_sum;
   logic [ID_W-1:0]   w_gidx;
   logic              w_accept;
   logic              w_fold;
   logic [WIDTH-1:0]  w_words [N_REQ];

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_words
      assign w_words[gi] = req_data[gi*WIDTH +: WIDTH];
   end

   // Rotate so bit 0 is the requester at ptr; lowest set bit is the winner.
   always_comb begin
      w_rot   = N_REQ'({req_valid, req_valid} >> r_ptr);
      w_found = 1'b0;
      w_off   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_found = 1'b1;
            w_off   = ID_W'(k);
         end
      end
      w_sum = {1'b0, r_ptr} + {1'b0, w_off};
      if (w_sum >= c_n) w_sum = w_sum - c_n;
      w_gidx = w_sum[ID_W-1:0];
   end

   assign w_accept  = (r_state == ST_IDLE) && w_found;
   assign req_ready = w_accept ? (N_REQ'(1) << w_gidx) : '0;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_accept)        w_state_nxt = ST_SHIFT;
         ST_SHIFT: if (r_cnt == c_last) w_state_nxt = ST_DONE;
         ST_DONE:  if (res_ready)       w_state_nxt = ST_IDLE;
         default:                       w_state_nxt = ST_IDLE;
      endcase
   end

   xor_gate u_xor (
      .i_a (r_acc),
      .i_b (r_sh[0]),
      .o_y (w_fold)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_sh    <= '0;
         r_acc   <= 1'b0;
         r_cnt   <= '0;
         r_id    <= '0;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_sh  <= w_words[w_gidx];
            r_acc <= 1'b0;
            r_cnt <= '0;
            r_id  <= w_gidx;
            r_ptr <= (w_gidx == c_id_max) ? '0 : w_gidx + 1'b1;
         end else if (r_state == ST_SHIFT) begin
            r_acc <= w_fold;
            r_sh  <= r_sh >> 1;
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign res_valid  = (r_state == ST_DONE);
   assign res_parity = r_acc;
   assign res_id     = r_id;

endmodule

`default_nettype wire

// File: tb/tb_xor_parity_arbiter.sv
// Directed bench for xor_parity_arbiter with a cycle-level reference model.
`default_nettype none

module tb_xor_parity_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid, req_ready;
   logic [N*W-1:0] req_data;
   logic           res_valid, res_parity, res_ready;
   logic [1:0]     res_id;

   logic           rst5;
   logic [1:0]     v5, rdy5;
   logic [9:0]     d5;
   logic           rv5, rp5, rr5;
   logic [0:0]     rid5;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   xor_parity_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .res_valid(res_valid), .res_parity(res_parity),
      .res_id(res_id), .res_ready(res_ready)
   );

   xor_parity_arbiter #(.N_REQ(2), .WIDTH(5)) dut5 (
      .clk(clk), .rst(rst5), .req_valid(v5), .req_data(d5),
      .req_ready(rdy5), .res_valid(rv5), .res_parity(rp5),
      .res_id(rid5), .res_ready(rr5)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Reference model: idle/busy/result phases, parity by reduction XOR.
   int   m_mode = 0, m_left = 0, m_ptr = 0, m_id = 0;
   logic m_par = 1'b0;
   bit   m_armed = 1'b0;

   always @(negedge clk) begin
      logic [N-1:0] exp_rdy;
      int g, idx;
      g = -1;
      exp_rdy = '0;
      if (m_mode == 0) begin
         for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (g < 0 && req_valid[idx] === 1'b1) g = idx;
         end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      if (m_armed) begin
         check("model_req_ready", req_ready, exp_rdy);
         check("model_res_valid", res_valid, m_mode == 2);
         if (m_mode == 2) begin
            check("model_res_parity", res_parity, m_par);
            check("model_res_id", res_id, m_id);
         end
      end
      if (rst) begin
         m_armed = 1'b1;
         m_mode  = 0;
         m_ptr   = 0;
      end else if (m_mode == 0 && g >= 0) begin
         m_mode = 1;
         m_left = W;
         m_par  = ^req_data[g*W +: W];
         m_id   = g;
         m_ptr  = (g + 1) % N;
      end else if (m_mode == 1) begin
         m_left--;
         if (m_left == 0) m_mode = 2;
      end else if (m_mode == 2 && res_ready) begin
         m_mode = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic grant(input logic [N-1:0] exp, input string nm);
      int n;
      n = 0;
      @(negedge clk);
      while (req_ready == '0 && n < 40) begin
         tick();
         @(negedge clk);
         n++;
      end
      check(nm, req_ready, exp);
      tick();
   endtask

   task automatic wait_res(input string nm);
      int n;
      n = 0;
      @(negedge clk);
      while (res_valid !== 1'b1 && n < 40) begin
         tick();
         @(negedge clk);
         n++;
      end
      check(nm, res_valid, 1'b1);
   endtask

   initial begin
      int got, cyc;
      int ids [6];
      int at [6];
      int exp_seq [6];
      logic cap_p;
      exp_seq = '{0, 1, 2, 3, 0, 1};

      rst = 1'b1; req_valid = '0; req_data = '0; res_ready = 1'b1;
      rst5 = 1'b1; v5 = '0; d5 = '0; rr5 = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; rst5 = 1'b0;
      @(negedge clk);
      check("reset_res_valid", res_valid, 1'b0);
      check("reset_res_parity", res_parity, 1'b0);
      check("reset_res_id", res_id, 2'd0);
      check("reset_req_ready", req_ready, 4'b0000);
      check("reset_w5_valid", rv5, 1'b0);

      // WIDTH=5: odd parity, result at accept+6
      tick();
      v5 = 2'b01;
      d5 = {5'b00000, 5'b10101};
      @(negedge clk);
      check("w5_ready", rdy5, 2'b01);
      tick();
      v5 = 2'b00;
      repeat (4) tick();
      @(negedge clk);
      check("w5_not_yet", rv5, 1'b0);
      tick();
      @(negedge clk);
      check("w5_valid", rv5, 1'b1);
      check("w5_parity", rp5, 1'b1);
      check("w5_id", rid5, 1'b0);

      // Single request, requester 2, result at accept+9
      tick();
      req_data[2*W +: W] = 8'b1011_0001;
      req_valid = 4'b0100;
      @(negedge clk);
      check("single_ready", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      @(negedge clk);
      check("single_ready_after", req_ready, 4'b0000);
      repeat (7) tick();
      @(negedge clk);
      check("single_not_yet", res_valid, 1'b0);
      tick();
      @(negedge clk);
      check("single_valid", res_valid, 1'b1);
      check("single_parity", res_parity, 1'b0);
      check("single_id", res_id, 2'd2);

      // Reset in the 4th SHIFT cycle aborts the job and clears ptr
      tick();
      req_data[1*W +: W] = 8'hFF;
      req_valid = 4'b0010;
      @(negedge clk);
      check("mid_ready", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("abort_no_result", res_valid, 1'b0);
         tick();
      end
      req_data[1*W +: W] = 8'h07;
      req_data[3*W +: W] = 8'h01;
      req_valid = 4'b1010;
      @(negedge clk);
      check("post_reset_grant", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      wait_res("post_reset_result");
      check("post_reset_parity", res_parity, 1'b1);
      check("post_reset_id", res_id, 2'd1);

      // Fairness with all requesters continuously valid
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'($urandom);
      req_valid = '1;
      got = 0;
      cyc = 0;
      while (got < 6 && cyc < 100) begin
         @(negedge clk);
         if (req_ready != '0) begin
            for (int k = 0; k < N; k++) if (req_ready[k]) ids[got] = k;
            at[got] = cyc;
            got++;
         end
         if (got < 6) tick();
         cyc++;
      end
      check("fairness_grants", got, 6);
      for (int i = 0; i < got; i++) begin
         check("fairness_id", ids[i], exp_seq[i]);
         if (i > 0) check("fairness_spacing", at[i] - at[i-1], W + 2);
      end
      tick();

      // Backpressure on the result of requester 1
      res_ready = 1'b0;
      wait_res("bp_result");
      cap_p = res_parity;
      for (int i = 0; i < 20; i++) begin
         tick();
         @(negedge clk);
         check("bp_valid_held", res_valid, 1'b1);
         check("bp_parity_held", res_parity, cap_p);
         check("bp_id_held", res_id, 2'd1);
         check("bp_no_ready", req_ready, 4'b0000);
      end
      tick();
      res_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ready", req_ready, 4'b0000);
      tick();
      @(negedge clk);
      check("bp_next_accept", req_ready, 4'b0100);
      tick();

      // Pointer wrap and skip
      grant(4'b1000, "wrap_grant3");
      req_valid = 4'b0010;
      grant(4'b0010, "skip_to_1");
      req_valid = 4'b1011;
      grant(4'b1000, "rr_after_1");
      req_valid = '0;
      wait_res("final_result");
      check("final_id", res_id, 2'd3);
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
